// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing the unified MIPS memory between the CPU and a DMA/loader.
// Registered owner with round-robin tie break and a burst limit; memory mux and acks follow the owner.
module mem_arbiter #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned MAXBURST = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             c_req,
    input  logic             c_we,
    input  logic [WIDTH-1:0] c_adr,
    input  logic [WIDTH-1:0] c_wd,
    output logic [WIDTH-1:0] c_rd,
    output logic             c_ack,
    input  logic             d_req,
    input  logic             d_we,
    input  logic [WIDTH-1:0] d_adr,
    input  logic [WIDTH-1:0] d_wd,
    output logic [WIDTH-1:0] d_rd,
    output logic             d_ack,
    output logic [WIDTH-1:0] m_adr,
    output logic [WIDTH-1:0] m_wd,
    output logic             m_we,
    input  logic [WIDTH-1:0] m_rd,
    output logic [1:0]       owner
);

    localparam int unsigned BW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CPU  = 2'b01,
        DMA  = 2'b10
    } owner_t;

    owner_t        state;
    logic          last;
    logic [BW-1:0] bcnt;
    logic [BW-1:0] bcnt_inc;
    logic          under_limit;

    // One more acked cycle still leaves the owner inside its burst allowance.
    assign under_limit = (({1'b0, bcnt} + (BW+1)'(1)) < (BW+1)'(MAXBURST));
    assign bcnt_inc    = (bcnt == {BW{1'b1}}) ? bcnt : bcnt + BW'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            last  <= 1'b1;
            bcnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bcnt <= '0;
                    if (c_req && d_req) state <= last ? CPU : DMA;
                    else if (c_req)     state <= CPU;
                    else if (d_req)     state <= DMA;
                    else                state <= IDLE;
                end
                CPU: begin
                    if (c_req) last <= 1'b0;
                    if (c_req && (!d_req || under_limit)) begin
                        state <= CPU;
                        bcnt  <= bcnt_inc;
                    end else begin
                        state <= d_req ? DMA : IDLE;
                        bcnt  <= '0;
                    end
                end
                DMA: begin
                    if (d_req) last <= 1'b1;
                    if (d_req && (!c_req || under_limit)) begin
                        state <= DMA;
                        bcnt  <= bcnt_inc;
                    end else begin
                        state <= c_req ? CPU : IDLE;
                        bcnt  <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    bcnt  <= '0;
                end
            endcase
        end
    end

    // Memory port follows the current owner; idle drives zeros.
    always_comb begin
        m_adr = '0;
        m_wd  = '0;
        m_we  = 1'b0;
        case (state)
            CPU: begin
                m_adr = c_adr;
                m_wd  = c_wd;
                m_we  = c_we & c_req;
            end
            DMA: begin
                m_adr = d_adr;
                m_wd  = d_wd;
                m_we  = d_we & d_req;
            end
            default: ;
        endcase
    end

    assign c_ack = (state == CPU) & c_req;
    assign d_ack = (state == DMA) & d_req;
    assign c_rd  = m_rd;
    assign d_rd  = m_rd;
    assign owner = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios, then random traffic against a grant/memory model.
module tb_mem_arbiter;

    localparam int unsigned W  = 32;
    localparam int unsigned MB = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         c_req, c_we, d_req, d_we, c_ack, d_ack, m_we;
    logic [W-1:0] c_adr, c_wd, c_rd, d_adr, d_wd, d_rd, m_adr, m_wd, m_rd;
    logic [1:0]   owner;

    logic [W-1:0] mem     [0:63] = '{default: '0};
    logic [W-1:0] ref_mem [0:63] = '{default: '0};

    int total = 0;
    int bad   = 0;

    mem_arbiter #(.WIDTH(W), .MAXBURST(MB)) dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_adr(c_adr), .c_wd(c_wd), .c_rd(c_rd), .c_ack(c_ack),
        .d_req(d_req), .d_we(d_we), .d_adr(d_adr), .d_wd(d_wd), .d_rd(d_rd), .d_ack(d_ack),
        .m_adr(m_adr), .m_wd(m_wd), .m_we(m_we), .m_rd(m_rd), .owner(owner)
    );

    always #5 clk = ~clk;

    assign m_rd = mem[m_adr[7:2]];
    always @(posedge clk) if (m_we) mem[m_adr[7:2]] <= m_wd;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] cpat, dpat;
        int          both, w, g, nxt, run, run_after, cw, dw;
        bit          last_dma, ca, da, exp_we;
        logic [W-1:0] exp_adr, exp_wd;

        reset = 1'b0;
        c_req = 1'b1; c_we = 1'b0; c_adr = '0; c_wd = '0;
        d_req = 1'b1; d_we = 1'b0; d_adr = '0; d_wd = '0;

        // Reset held with both requesting.
        repeat (2) @(negedge clk);
        chk("rst_owner", 32'(owner), 32'h0);
        chk("rst_mwe",   32'(m_we),  32'h0);
        chk("rst_madr",  m_adr,      32'h0);
        chk("rst_cack",  32'(c_ack), 32'h0);
        chk("rst_dack",  32'(d_ack), 32'h0);
        cyc();
        reset = 1'b1;
        @(negedge clk);
        chk("rel_idle", 32'(owner), 32'h0);
        @(negedge clk);
        chk("rel_cack", 32'(c_ack), 32'h1);
        chk("rel_dack", 32'(d_ack), 32'h0);
        cyc();
        c_req = 1'b0; d_req = 1'b0;
        cyc();

        // CPU alone: write then read back.
        c_req = 1'b1; c_we = 1'b1; c_adr = 32'h54; c_wd = 32'h7;
        @(negedge clk);
        chk("cw_latency", 32'(c_ack), 32'h0);
        cyc();
        @(negedge clk);
        chk("cw_ack",  32'(c_ack), 32'h1);
        chk("cw_mwe",  32'(m_we),  32'h1);
        chk("cw_madr", m_adr,      32'h54);
        cyc();
        c_we = 1'b0;
        @(negedge clk);
        chk("cr_ack", 32'(c_ack), 32'h1);
        chk("cr_rd",  c_rd,       32'h7);
        cyc();
        c_req = 1'b0;
        cyc();

        // DMA loads four words back to back.
        d_req = 1'b1; d_we = 1'b1; d_adr = 32'h0; d_wd = 32'hA0;
        cyc();
        for (int i = 0; i < 4; i++) begin
            d_adr = 32'(i * 4);
            d_wd  = 32'(32'hA0 + i);
            @(negedge clk);
            chk("dma_burst", 32'(d_ack), 32'h1);
            cyc();
        end
        d_req = 1'b0; d_we = 1'b0;
        cyc();
        c_req = 1'b1; c_adr = 32'h8;
        cyc();
        @(negedge clk);
        chk("dma_rb_ack", 32'(c_ack), 32'h1);
        chk("dma_rb_rd",  c_rd,       32'hA2);
        cyc();
        c_req = 1'b0;
        cyc();

        // Contention with both requests held: CCCC DDDD CCCC.
        c_req = 1'b1; c_adr = 32'h4;
        cyc();
        d_req = 1'b1; d_adr = 32'hC;
        cpat = '0; dpat = '0; both = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            cpat[i] = c_ack;
            dpat[i] = d_ack;
            if (c_ack && d_ack) both++;
            cyc();
        end
        chk("cont_cpat", 32'(cpat), 32'hF0F);
        chk("cont_dpat", 32'(dpat), 32'h0F0);
        chk("cont_both", 32'(both), 32'h0);
        c_req = 1'b0; d_req = 1'b0;
        cyc();
        cyc();

        // DMA streaming, CPU asks once.
        d_req = 1'b1; d_we = 1'b1; d_adr = 32'h40; d_wd = 32'hDEAD;
        cyc();
        cyc();
        c_req = 1'b1; c_we = 1'b0; c_adr = 32'h20; c_wd = 32'h1111;
        w = 0;
        @(negedge clk);
        while (!c_ack && w < 10) begin
            cyc();
            @(negedge clk);
            w++;
        end
        chk("cpu_wait", 32'(c_ack && w <= 5), 32'h1);
        chk("cpu_mwe",  32'(m_we), 32'h0);
        chk("cpu_mwd",  m_wd,      32'h1111);
        chk("cpu_madr", m_adr,     32'h20);
        chk("cpu_rd",   c_rd,      32'h0);
        cyc();
        c_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        cyc();
        cyc();

        // Reset asserted in the middle of a write.
        c_req = 1'b1; c_we = 1'b1; c_adr = 32'h30; c_wd = 32'h55;
        cyc();
        @(negedge clk);
        chk("rw_mwe_pre", 32'(m_we), 32'h1);
        #2 reset = 1'b0;
        #1;
        chk("rw_mwe_async", 32'(m_we),  32'h0);
        chk("rw_owner",     32'(owner), 32'h0);
        cyc();
        chk("rw_mem", mem[12], 32'h0);
        reset = 1'b1; c_req = 1'b0; c_we = 1'b0;
        @(negedge clk);
        chk("rw_idle", 32'(owner), 32'h0);

        // Random traffic in the upper half of memory, modelled as grants and served runs.
        cyc();
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        g = 0; run = 0; last_dma = 1'b1; cw = 0; dw = 0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            ca = (g == 1) && c_req;
            da = (g == 2) && d_req;
            exp_adr = (g == 1) ? c_adr : (g == 2) ? d_adr : '0;
            exp_wd  = (g == 1) ? c_wd  : (g == 2) ? d_wd  : '0;
            exp_we  = (g == 1) ? (c_we && c_req) : (g == 2) ? (d_we && d_req) : 1'b0;
            chk("r_owner", 32'(owner), 32'(g));
            chk("r_cack",  32'(c_ack), 32'(ca));
            chk("r_dack",  32'(d_ack), 32'(da));
            chk("r_mwe",   32'(m_we),  32'(exp_we));
            chk("r_madr",  m_adr,      exp_adr);
            chk("r_mwd",   m_wd,       exp_wd);
            if (ca) begin
                if (c_we) ref_mem[c_adr[7:2]] = c_wd;
                else      chk("r_crd", c_rd, ref_mem[c_adr[7:2]]);
                chk("r_cwait", 32'(cw <= int'(MB) + 1), 32'h1);
                cw = 0;
            end else if (c_req) cw++;
            if (da) begin
                if (d_we) ref_mem[d_adr[7:2]] = d_wd;
                else      chk("r_drd", d_rd, ref_mem[d_adr[7:2]]);
                chk("r_dwait", 32'(dw <= int'(MB) + 1), 32'h1);
                dw = 0;
            end else if (d_req) dw++;

            run_after = (ca || da) ? ((run < 15) ? run + 1 : 15) : run;
            if (ca) last_dma = 1'b0;
            if (da) last_dma = 1'b1;
            if (g == 0)
                nxt = (c_req && d_req) ? (last_dma ? 1 : 2) : c_req ? 1 : d_req ? 2 : 0;
            else if (g == 1)
                nxt = (c_req && (!d_req || run_after < int'(MB))) ? 1 : d_req ? 2 : 0;
            else
                nxt = (d_req && (!c_req || run_after < int'(MB))) ? 2 : c_req ? 1 : 0;
            run = (nxt == g && nxt != 0) ? run_after : 0;
            g = nxt;

            cyc();
            if (ca || !c_req) begin
                c_req = ($urandom_range(0, 3) != 0);
                c_we  = 1'($urandom_range(0, 1));
                c_adr = 32'((32 + $urandom_range(0, 31)) * 4);
                c_wd  = $urandom;
            end
            if (da || !d_req) begin
                d_req = ($urandom_range(0, 3) != 0);
                d_we  = 1'($urandom_range(0, 1));
                d_adr = 32'((32 + $urandom_range(0, 31)) * 4);
                d_wd  = $urandom;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
